attack_sequencer: RTL and testbench

ATTACK_SEQUENCER -- requirements
Module: attack_sequencer

---
 rtl/attack_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_attack_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_sequencer.sv
// Attack sequencer: decodes a controller word into one attack, runs it through
// startup/active/cooldown phases and reports a single hit with its knockback.
`timescale 1ns / 1ps

module attack_sequencer #(
  parameter int unsigned TIMER_W      = 25,
  parameter int unsigned STARTUP_CYC  = 1048576,
  parameter int unsigned JAB_CYC      = 4194304,
  parameter int unsigned SMASH_CYC    = 8388608,
  parameter int unsigned SPECIAL_CYC  = 16777216,
  parameter int unsigned COOLDOWN_CYC = 2097152,
  parameter int unsigned KB_SHIFT     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] char1pos,
  input  logic [31:0] char1size,
  input  logic [31:0] char2pos,
  input  logic [31:0] char2size,
  input  logic [31:0] controls,
  output logic [31:0] attack,
  output logic [31:0] knockback,
  output logic [31:0] movement,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StStartup  = 2'b01,
    StActive   = 2'b10,
    StCooldown = 2'b11
  } stateT;

  // Encoding equals the attack[] bit index of each class.
  typedef enum logic [3:0] {
    AtkNone     = 4'd0,
    AtkSmashU   = 4'd1,
    AtkSmashD   = 4'd2,
    AtkSmashL   = 4'd3,
    AtkSmashR   = 4'd4,
    AtkJab      = 4'd5,
    AtkSpecialU = 4'd6,
    AtkSpecialD = 4'd7,
    AtkSpecialL = 4'd8,
    AtkSpecialR = 4'd9,
    AtkNeutral  = 4'd10
  } atkT;

  typedef enum logic [1:0] {DirL, DirR, DirU, DirD} dirT;

  localparam logic [TIMER_W-1:0] StartupLen  = TIMER_W'(STARTUP_CYC);
  localparam logic [TIMER_W-1:0] JabLen      = TIMER_W'(JAB_CYC);
  localparam logic [TIMER_W-1:0] SmashLen    = TIMER_W'(SMASH_CYC);
  localparam logic [TIMER_W-1:0] SpecialLen  = TIMER_W'(SPECIAL_CYC);
  localparam logic [TIMER_W-1:0] CooldownLen = TIMER_W'(COOLDOWN_CYC);

  stateT              stateQ, stateD;
  logic [TIMER_W-1:0] cntQ, cntD, activeLen;
  atkT                codeQ, codeD, reqCode;
  dirT                dirQ, dirD, reqDir;
  logic               faceQ, faceD, hitQ, hitD, phaseDone;
  logic [31:0]        attackQ, attackD, kbQ, kbD, movQ, movD, kbRaw, kbShifted;

  logic facing, stickL, stickR, stickU, stickD, unusedCtl;
  assign facing    = controls[26];
  assign stickL    = (controls[15:13] == 3'b000);
  assign stickR    = (controls[15:13] == 3'b111);
  assign stickU    = (controls[7:5] == 3'b111);
  assign stickD    = (controls[7:5] == 3'b000);
  assign unusedCtl = ^{controls[31:27], controls[25:24], controls[19:18], controls[12:8],
                       controls[4:0]};

  always_comb begin
    reqCode = AtkNone;
    reqDir  = facing ? DirR : DirL;
    if (controls[23]) begin
      reqCode = AtkSmashL;
      reqDir  = DirL;
    end else if (controls[22]) begin
      reqCode = AtkSmashR;
      reqDir  = DirR;
    end else if (controls[21]) begin
      reqCode = AtkSmashU;
      reqDir  = DirU;
    end else if (controls[20]) begin
      reqCode = AtkSmashD;
      reqDir  = DirD;
    end else if (controls[16]) begin
      reqCode = AtkJab;
    end else if (controls[17]) begin
      if (stickL) begin
        reqCode = AtkSpecialL;
        reqDir  = DirL;
      end else if (stickR) begin
        reqCode = AtkSpecialR;
        reqDir  = DirR;
      end else if (stickU) begin
        reqCode = AtkSpecialU;
        reqDir  = DirU;
      end else if (stickD) begin
        reqCode = AtkSpecialD;
        reqDir  = DirD;
      end else begin
        reqCode = AtkNeutral;
      end
    end
  end

  always_comb begin
    case (codeQ)
      AtkJab:                                       activeLen = JabLen;
      AtkSmashU, AtkSmashD, AtkSmashL, AtkSmashR: activeLen = SmashLen;
      default:                                      activeLen = SpecialLen;
    endcase
  end

  // Hitbox geometry, all 16-bit modulo.
  logic [15:0] posX, posY, sizeX, sizeY, boxW, boxH, boxX, boxY;
  logic [15:0] c2x, c2y, c2w, c2h;
  logic        overlap;
  assign posX  = char1pos[31:16];
  assign posY  = char1pos[15:0];
  assign sizeX = char1size[31:16];
  assign sizeY = char1size[15:0];
  assign c2x   = char2pos[31:16];
  assign c2y   = char2pos[15:0];
  assign c2w   = char2size[31:16];
  assign c2h   = char2size[15:0];
  assign boxW  = sizeX >> 1;
  assign boxH  = sizeY >> 1;

  always_comb begin
    unique case (dirQ)
      DirL: begin boxX = posX - boxW;        boxY = posY + (boxH >> 1); end
      DirR: begin boxX = posX + sizeX;       boxY = posY + (boxH >> 1); end
      DirU: begin boxX = posX + (boxW >> 1); boxY = posY + sizeY;       end
      DirD: begin boxX = posX + (boxW >> 1); boxY = posY - (boxH >> 1); end
    endcase
  end

  assign overlap = (boxX < 16'(c2x + c2w)) && (c2x < 16'(boxX + boxW)) &&
                   (boxY < 16'(c2y + c2h)) && (c2y < 16'(boxY + boxH));

  always_comb begin
    case (codeQ)
      AtkSmashU:   kbRaw = 32'h0000_0800;
      AtkSmashD:   kbRaw = 32'h0000_F7FE;
      AtkSmashL:   kbRaw = 32'hF7FE_00E0;
      AtkSmashR:   kbRaw = 32'h0800_00E0;
      AtkJab:      kbRaw = faceQ ? 32'h0400_0080 : 32'hFBFE_0080;
      AtkSpecialL: kbRaw = 32'hFC00_0040;
      AtkSpecialR: kbRaw = 32'h0400_0040;
      AtkSpecialU: kbRaw = 32'h0000_0400;
      AtkSpecialD: kbRaw = 32'h0000_FC00;
      AtkNeutral:  kbRaw = faceQ ? 32'h0400_0040 : 32'hFC00_0040;
      default:     kbRaw = 32'h0000_0000;
    endcase
  end

  logic signed [15:0] kbHi, kbLo;
  assign kbHi      = $signed(kbRaw[31:16]) >>> KB_SHIFT;
  assign kbLo      = $signed(kbRaw[15:0]) >>> KB_SHIFT;
  assign kbShifted = {kbHi, kbLo};

  // Next state; the counter is reloaded on every state entry and stops at zero.
  assign phaseDone = (cntQ <= TIMER_W'(1));

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    codeD  = codeQ;
    dirD   = dirQ;
    faceD  = faceQ;
    unique case (stateQ)
      StIdle: begin
        if (reqCode != AtkNone) begin
          stateD = StStartup;
          cntD   = StartupLen;
          codeD  = reqCode;
          dirD   = reqDir;
          faceD  = facing;
        end
      end
      StStartup: begin
        if (phaseDone) begin
          stateD = StActive;
          cntD   = activeLen;
        end else begin
          cntD = cntQ - TIMER_W'(1);
        end
      end
      StActive: begin
        if (phaseDone) begin
          stateD = StCooldown;
          cntD   = CooldownLen;
        end else begin
          cntD = cntQ - TIMER_W'(1);
        end
      end
      StCooldown: begin
        if (phaseDone) begin
          stateD = StIdle;
          cntD   = '0;
        end else begin
          cntD = cntQ - TIMER_W'(1);
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    attackD          = '0;
    movD             = '0;
    kbD              = kbQ;
    hitD             = hitQ;
    attackD[13:12]   = stateD;
    if (stateQ == StIdle && stateD == StStartup) hitD = 1'b0;
    if (stateD == StActive) begin
      attackD[{1'b0, codeQ}] = 1'b1;
      attackD[11]            = 1'b1;
      if (overlap && !hitQ) begin
        attackD[0] = 1'b1;
        hitD       = 1'b1;
        kbD        = kbShifted;
      end
      if (codeQ == AtkSpecialU) movD = 32'h0000_0010;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      codeQ   <= AtkNone;
      dirQ    <= DirL;
      faceQ   <= 1'b0;
      hitQ    <= 1'b0;
      attackQ <= '0;
      kbQ     <= '0;
      movQ    <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      codeQ   <= codeD;
      dirQ    <= dirD;
      faceQ   <= faceD;
      hitQ    <= hitD;
      attackQ <= attackD;
      kbQ     <= kbD;
      movQ    <= movD;
    end
  end

  assign attack    = attackQ;
  assign knockback = kbQ;
  assign movement  = movQ;
  assign busy      = (stateQ != StIdle);

endmodule

// File: tb/tb_attack_sequencer.sv
// Randomized scoreboard bench for attack_sequencer: stimulus pushes expected per-attack
// summaries, a monitor accumulates what the DUT shows and compares when each attack ends.
`timescale 1ns / 1ps

module tb_attack_sequencer;

  localparam int StartupC  = 2;
  localparam int JabC      = 4;
  localparam int SmashC    = 6;
  localparam int SpecialC  = 6;
  localparam int CooldownC = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] char1pos = '0, char1size = '0, char2pos = '0, char2size = '0, controls = '0;
  logic [31:0] attack, knockback, movement;
  logic        busy;

  always #5 clock = ~clock;

  attack_sequencer #(
    .TIMER_W(8), .STARTUP_CYC(StartupC), .JAB_CYC(JabC), .SMASH_CYC(SmashC),
    .SPECIAL_CYC(SpecialC), .COOLDOWN_CYC(CooldownC), .KB_SHIFT(0)
  ) dut (
    .clock(clock), .reset(reset), .char1pos(char1pos), .char1size(char1size),
    .char2pos(char2pos), .char2size(char2size), .controls(controls),
    .attack(attack), .knockback(knockback), .movement(movement), .busy(busy)
  );

  typedef struct {
    int          bitIdx;
    int          len;
    int          busyCyc;
    int          pulses;
    logic [31:0] kb;
    int          movCyc;
  } expT;

  expT         expQ[$];
  int          nVec = 0, nFail = 0, nPushed = 0, nPopped = 0;
  logic [31:0] modelKb = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nVec++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference decode: class bit, hitbox direction (0=L 1=R 2=U 3=D), knockback, active length.
  task automatic decide(input logic [31:0] c, output int bitIdx, output int dir,
                        output logic [31:0] kb, output int len);
    logic       face;
    logic [2:0] sx, sy;
    face = c[26];
    sx   = c[15:13];
    sy   = c[7:5];
    len  = SmashC;
    if (c[23])      begin bitIdx = 3; dir = 0; kb = 32'hF7FE00E0; end
    else if (c[22]) begin bitIdx = 4; dir = 1; kb = 32'h080000E0; end
    else if (c[21]) begin bitIdx = 1; dir = 2; kb = 32'h00000800; end
    else if (c[20]) begin bitIdx = 2; dir = 3; kb = 32'h0000F7FE; end
    else if (c[16]) begin
      bitIdx = 5; dir = face ? 1 : 0; len = JabC;
      kb = face ? 32'h04000080 : 32'hFBFE0080;
    end else begin
      len = SpecialC;
      if (sx == 3'b000)      begin bitIdx = 8; dir = 0; kb = 32'hFC000040; end
      else if (sx == 3'b111) begin bitIdx = 9; dir = 1; kb = 32'h04000040; end
      else if (sy == 3'b111) begin bitIdx = 6; dir = 2; kb = 32'h00000400; end
      else if (sy == 3'b000) begin bitIdx = 7; dir = 3; kb = 32'h0000FC00; end
      else begin
        bitIdx = 10; dir = face ? 1 : 0;
        kb = face ? 32'h04000040 : 32'hFC000040;
      end
    end
  endtask

  task automatic hitbox(input int dir, input logic [31:0] p, input logic [31:0] s,
                        output int hx, output int hy, output int w, output int h);
    int x, y, sx, sy;
    x = int'(p[31:16]); y = int'(p[15:0]); sx = int'(s[31:16]); sy = int'(s[15:0]);
    w = sx / 2; h = sy / 2;
    case (dir)
      0:       begin hx = x - w;     hy = y + h / 2; end
      1:       begin hx = x + sx;    hy = y + h / 2; end
      2:       begin hx = x + w / 2; hy = y + sy;    end
      default: begin hx = x + w / 2; hy = y - h / 2; end
    endcase
    hx = hx & 65535;
    hy = hy & 65535;
  endtask

  function automatic bit overlaps(input int hx, input int hy, input int w, input int h,
                                  input logic [31:0] p2, input logic [31:0] s2);
    int x2, y2, w2, h2;
    x2 = int'(p2[31:16]); y2 = int'(p2[15:0]); w2 = int'(s2[31:16]); h2 = int'(s2[15:0]);
    return (hx < ((x2 + w2) & 65535)) && (x2 < ((hx + w) & 65535)) &&
           (hy < ((y2 + h2) & 65535)) && (y2 < ((hy + h) & 65535));
  endfunction

  // Drives geometry for one attack and returns the expected summary; ovl: 0 miss, 1 hit, 2 random.
  task automatic prepare(input logic [31:0] c, input int ovl, output expT e);
    int bitIdx, dir, len, hx, hy, w, h;
    logic [31:0] kb, p1, s1, p2, s2;
    bit want, ov;
    decide(c, bitIdx, dir, kb, len);
    p1 = {16'($urandom_range(2000, 40000)), 16'($urandom_range(2000, 40000))};
    s1 = {16'($urandom_range(8, 400)), 16'($urandom_range(8, 400))};
    hitbox(dir, p1, s1, hx, hy, w, h);
    want = (ovl == 2) ? bit'($urandom_range(0, 1)) : bit'(ovl);
    s2 = {16'($urandom_range(1, 100)), 16'($urandom_range(1, 100))};
    if (want) p2 = {16'(hx), 16'(hy)};
    else      p2 = {16'(hx + w + 1000), 16'(hy)};
    ov = overlaps(hx, hy, w, h, p2, s2);
    if (ov) modelKb = kb;
    e = '{bitIdx, len, StartupC + len + CooldownC, ov ? 1 : 0, modelKb,
          (bitIdx == 6) ? len : 0};
    char1pos = p1; char1size = s1; char2pos = p2; char2size = s2;
  endtask

  task automatic waitBusy(input logic level, input string what);
    int n = 0;
    while (busy !== level) begin
      @(negedge clock);
      n++;
      if (n > 100) begin
        check({"timeout ", what}, 32'(busy), 32'(level));
        return;
      end
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic runAttack(input logic [31:0] c, input int ovl, input bit hold);
    expT e;
    int  idle;
    prepare(c, ovl, e);
    expQ.push_back(e);
    nPushed++;
    if (hold) begin
      expQ.push_back(e);
      nPushed++;
    end
    controls = c;
    @(negedge clock);
    check("busy after request", 32'(busy), 32'd1);
    if (hold) begin
      waitBusy(1'b0, "first attack end");
      idle = 1;
      @(negedge clock);
      while (!busy && idle < 10) begin
        idle++;
        @(negedge clock);
      end
      check("idle gap before held request", idle, 1);
    end
    controls = '0;
    waitBusy(1'b0, "attack end");
  endtask

  function automatic logic [31:0] randCtl();
    logic [31:0] c;
    c = $urandom;
    if ($urandom_range(0, 2) != 0) c[23:20] = 4'b0000;
    if ($urandom_range(0, 1) != 0) c[16] = 1'b0;
    if ($urandom_range(0, 1) != 0) c[15:13] = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
    if ($urandom_range(0, 1) != 0) c[7:5] = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
    if (c[23:20] == 4'b0000 && !c[16]) c[17] = 1'b1;
    return c;
  endfunction

  // Monitor: accumulate per-attack observations and score them when busy falls.
  initial begin
    int  busyCnt, pulseCnt, pulseAct, movCnt, movBad, other;
    int  bitCnt[1:10];
    bit  prevBusy, ok;
    expT e;
    busyCnt = 0; pulseCnt = 0; pulseAct = 0; movCnt = 0; movBad = 0; prevBusy = 0;
    foreach (bitCnt[i]) bitCnt[i] = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busyCnt = 0; pulseCnt = 0; pulseAct = 0; movCnt = 0; movBad = 0; prevBusy = 0;
        foreach (bitCnt[i]) bitCnt[i] = 0;
      end else begin
        ok = (attack[11] == (|attack[10:1])) && (attack[31:14] == '0) &&
             ((attack[13:12] != 2'b00) == busy) &&
             (busy || (attack[0] == 1'b0 && movement == '0));
        nVec++;
        if (!ok) begin
          nFail++;
          $display("FAIL status invariant: got attack=%h busy=%b movement=%h", attack, busy,
                   movement);
        end
        if (busy) begin
          busyCnt++;
          for (int i = 1; i <= 10; i++) if (attack[i]) bitCnt[i]++;
          if (attack[0]) begin
            pulseCnt++;
            if (attack[10:1] != '0) pulseAct++;
          end
          if (movement != '0) begin
            movCnt++;
            if (movement != 32'h10) movBad++;
          end
        end
        if (prevBusy && !busy) begin
          if (expQ.size() == 0) begin
            check("unexpected attack", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            nPopped++;
            other = 0;
            for (int i = 1; i <= 10; i++) if (i != e.bitIdx) other += bitCnt[i];
            check("busy cycles", busyCnt, e.busyCyc);
            check("class bit cycles", bitCnt[e.bitIdx], e.len);
            check("other class bit cycles", other, 0);
            check("hit pulses", pulseCnt, e.pulses);
            check("pulses outside active", pulseCnt - pulseAct, 0);
            check("knockback", knockback, e.kb);
            check("movement cycles", movCnt, e.movCyc);
            check("movement value errors", movBad, 0);
          end
          busyCnt = 0; pulseCnt = 0; pulseAct = 0; movCnt = 0; movBad = 0;
          foreach (bitCnt[i]) bitCnt[i] = 0;
        end
        prevBusy = busy;
      end
    end
  end

  initial begin
    expT e;
    int  n;
    reset = 1'b1;
    @(negedge clock);
    check("reset attack", attack, 32'd0);
    check("reset knockback", knockback, 32'd0);
    check("reset movement", movement, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Jab facing right onto an overlapping target.
    runAttack(32'h0401_0000 | (32'd3 << 13) | (32'd3 << 5), 1, 1'b0);
    // smashL and jab together: smash wins.
    runAttack((32'd1 << 23) | (32'd1 << 16), 1, 1'b0);
    // Up special moves the character.
    runAttack((32'd1 << 17) | (32'd3 << 13) | (32'd7 << 5), 1, 1'b0);
    // Smash held through cooldown: one restart after a single idle cycle.
    runAttack(32'd1 << 21, 1, 1'b1);
    // Miss: no pulse, knockback held.
    runAttack(32'd1 << 20, 0, 1'b0);
    // Neutral special facing left.
    runAttack((32'd1 << 17) | (32'd3 << 13) | (32'd3 << 5), 1, 1'b0);

    // Reset during ACTIVE discards the attack.
    prepare(32'd1 << 22, 1, e);
    controls = 32'd1 << 22;
    @(negedge clock);
    controls = '0;
    n = 0;
    while (attack[10:1] == '0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("reached active before reset", 32'(attack[10:1] != '0), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("async reset attack", attack, 32'd0);
    check("async reset knockback", knockback, 32'd0);
    check("async reset movement", movement, 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    modelKb = '0;
    @(negedge clock);
    #3 reset = 1'b0;
    @(negedge clock);
    check("busy after reset release", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) runAttack(randCtl(), 2, ($urandom_range(0, 7) == 0));

    repeat (3) @(negedge clock);
    check("scoreboard drained", nPopped, nPushed);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
